packet_uart_tx: RTL and testbench

Serialises the fixed-length message packets produced by the command manager (`tx_data` / `send_data` / `data_sent` handshake) onto an asynchronous 8N1 serial line toward the host PC. Each packet is framed as a sync byte, the payload bytes MSB-first, and an XOR checksum byte. The block sits directly downstream of the command manager. It owns the physical TX pin.

---
 rtl/packet_uart_tx.sv | 123 ++++++++++++
 tb/tb_packet_uart_tx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/packet_uart_tx.sv
// Frames fixed-length packets as SYNC, payload (MSB byte first), XOR checksum
// and shifts them out on an 8N1 serial line, LSB first within each byte.
module packet_uart_tx #(
    parameter int         MSG_LENGTH   = 48,
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rsnt,
    input  logic [MSG_LENGTH-1:0] tx_data,
    input  logic                  send_data,
    output logic                  data_sent,
    output logic                  busy,
    output logic                  tx
);
    localparam int NBYTES = MSG_LENGTH / 8;
    localparam int BW     = $clog2(NBYTES + 2);
    localparam int CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES + 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

    state_t                state, state_nx;
    logic [MSG_LENGTH-1:0] shreg, shreg_nx;
    logic [CW-1:0]         baud, baud_nx;
    logic [2:0]            bit_idx, bit_nx;
    logic [BW-1:0]         byte_idx, byte_nx;
    logic                  tx_nx, sent_nx, busy_nx;
    logic [7:0]            csum, cur_byte;
    logic                  bit_end;

    assign bit_end = (baud == BAUD_LAST);

    // Checksum covers payload only; the latched copy never changes mid-frame.
    always_comb begin
        csum = '0;
        for (int i = 0; i < NBYTES; i++)
            csum = csum ^ shreg[8*i +: 8];
    end

    always_comb begin
        cur_byte = SYNC_BYTE;
        if (byte_idx == LAST_BYTE)
            cur_byte = csum;
        for (int i = 1; i <= NBYTES; i++)
            if (byte_idx == BW'(i))
                cur_byte = shreg[MSG_LENGTH-8*i +: 8];
    end

    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        baud_nx  = '0;
        bit_nx   = bit_idx;
        byte_nx  = byte_idx;
        tx_nx    = tx;
        sent_nx  = 1'b0;
        busy_nx  = busy;
        if (state == START || state == DATA || state == STOP)
            baud_nx = bit_end ? '0 : baud + 1'b1;
        unique case (state)
            IDLE: if (send_data) begin
                state_nx = START;
                shreg_nx = tx_data;
                byte_nx  = '0;
                tx_nx    = 1'b0;
                busy_nx  = 1'b1;
            end
            START: if (bit_end) begin
                state_nx = DATA;
                bit_nx   = '0;
                tx_nx    = cur_byte[0];
            end
            DATA: if (bit_end) begin
                if (bit_idx == 3'd7) begin
                    state_nx = STOP;
                    tx_nx    = 1'b1;
                end else begin
                    bit_nx = bit_idx + 3'd1;
                    tx_nx  = cur_byte[bit_idx + 3'd1];
                end
            end
            STOP: if (bit_end) begin
                if (byte_idx != LAST_BYTE) begin
                    byte_nx  = byte_idx + 1'b1;
                    state_nx = START;
                    tx_nx    = 1'b0;
                end else begin
                    state_nx = DONE;
                    sent_nx  = 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rsnt) begin
        if (!rsnt) begin
            state     <= IDLE;
            shreg     <= '0;
            baud      <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            tx        <= 1'b1;
            data_sent <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            shreg     <= shreg_nx;
            baud      <= baud_nx;
            bit_idx   <= bit_nx;
            byte_idx  <= byte_nx;
            tx        <= tx_nx;
            data_sent <= sent_nx;
            busy      <= busy_nx;
        end
    end
endmodule

// File: tb/tb_packet_uart_tx.sv
// Randomised bench for packet_uart_tx: decodes the serial line independently
// and compares against a byte-list model of the frame format.
module tb_packet_uart_tx;
    localparam int CPB       = 4;
    localparam int NBYTES    = 6;
    localparam int FRAME_CYC = (NBYTES + 2) * 10 * CPB;

    logic        clk = 1'b0, rsnt = 1'b0, send_data = 1'b0;
    logic [47:0] tx_data = '0;
    logic        data_sent, busy, tx;

    int total = 0, bad = 0, rd = 0;
    int edges = 0, sent_cnt = 0, busy_cyc = 0, frm_err = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    bit         mon_act = 1'b0;
    int         mon_cnt = 0;
    logic [9:0] mon_bits = '0;

    packet_uart_tx #(.MSG_LENGTH(48), .CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rsnt(rsnt), .tx_data(tx_data), .send_data(send_data),
        .data_sent(data_sent), .busy(busy), .tx(tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    // Line decoder: samples mid-bit, 10 bits per character.
    always @(negedge clk) begin
        if (!rsnt) begin
            mon_act = 1'b0;
        end else begin
            if (data_sent) sent_cnt++;
            if (busy) busy_cyc++;
            if (!mon_act) begin
                if (tx == 1'b0) begin mon_act = 1'b1; mon_cnt = 0; end
            end else mon_cnt++;
            if (mon_act && (mon_cnt % CPB) == CPB / 2) begin
                mon_bits[mon_cnt / CPB] = tx;
                if (mon_cnt / CPB == 9) begin
                    if (mon_bits[0] !== 1'b0 || mon_bits[9] !== 1'b1) frm_err++;
                    rx_q.push_back(mon_bits[8:1]);
                    mon_act = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic add_exp(input logic [47:0] d);
        logic [7:0] b, cs;
        cs = 8'h00;
        exp_q.push_back(8'hA5);
        for (int k = 0; k < NBYTES; k++) begin
            b = 8'(d >> (8 * (NBYTES - 1 - k)));
            exp_q.push_back(b);
            cs = cs ^ b;
        end
        exp_q.push_back(cs);
    endtask

    task automatic check_line(input string tag);
        logic [7:0] g;
        int n;
        n = exp_q.size();
        chk({tag, "_nbytes"}, rx_q.size() - rd, n);
        for (int i = 0; i < n; i++) begin
            g = (rd + i < rx_q.size()) ? rx_q[rd + i] : 8'hxx;
            chk(tag, g, exp_q[i]);
        end
        rd = rx_q.size();
        exp_q.delete();
    endtask

    // Caller sits at a negedge; returns with acc = number of the acceptance edge.
    task automatic send(input logic [47:0] d, input bit hold, output int acc);
        tx_data   = d;
        send_data = 1'b1;
        @(posedge clk);
        #1 acc = edges;
        if (!hold) begin
            @(negedge clk);
            send_data = 1'b0;
        end
    endtask

    // Returns at the negedge inside the data_sent cycle; releases any held request.
    task automatic wait_sent(output int e);
        bit seen;
        seen = 1'b0;
        e = -1;
        for (int i = 0; i < 3 * FRAME_CYC && !seen; i++) begin
            @(negedge clk);
            if (data_sent === 1'b1) begin
                seen = 1'b1;
                e = edges;
                send_data = 1'b0;
            end
        end
        chk("sent_seen", seen, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc, acc2, e, e2, base_s, base_b, viol;
        logic [47:0] a, b;
        bit hold;

        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sent", data_sent, 1'b0);
        rsnt = 1'b1;
        @(negedge clk);

        // Reference frame
        base_s = sent_cnt;
        add_exp(48'h0123456789AB);
        send(48'h0123456789AB, 1'b0, acc);
        wait_sent(e);
        chk("t1_latency", e - acc, FRAME_CYC);
        repeat (5) @(negedge clk);
        check_line("t1_bytes");
        chk("t1_sent", sent_cnt - base_s, 1);

        // All-zero payload, busy duration
        base_b = busy_cyc;
        add_exp(48'h0);
        send(48'h0, 1'b0, acc);
        wait_sent(e);
        repeat (5) @(negedge clk);
        check_line("t2_bytes");
        chk("t2_busy_cycles", busy_cyc - base_b, FRAME_CYC + 1);

        // Request held high until data_sent
        base_s = sent_cnt;
        a = {16'($urandom), $urandom};
        add_exp(a);
        send(a, 1'b1, acc);
        wait_sent(e);
        chk("t3_latency", e - acc, FRAME_CYC);
        viol = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1) viol++;
        end
        chk("t3_idle_viol", viol, 0);
        chk("t3_sent", sent_cnt - base_s, 1);
        check_line("t3_bytes");

        // Request while busy is dropped
        base_s = sent_cnt;
        add_exp(48'h0123456789AB);
        send(48'h0123456789AB, 1'b0, acc);
        repeat (100) @(negedge clk);
        tx_data = 48'hFFFFFFFFFFFF;
        send_data = 1'b1;
        @(negedge clk);
        send_data = 1'b0;
        wait_sent(e);
        chk("t4_latency", e - acc, FRAME_CYC);
        repeat (60) @(negedge clk);
        check_line("t4_bytes");
        chk("t4_sent", sent_cnt - base_s, 1);

        // Reset during payload byte 2 data bits
        send(48'h0123456789AB, 1'b0, acc);
        repeat (88) @(negedge clk);
        base_s = sent_cnt;
        rsnt = 1'b0;
        #1;
        chk("t5_rst_tx", tx, 1'b1);
        chk("t5_rst_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        rsnt = 1'b1;
        repeat (50) @(negedge clk);
        chk("t5_no_sent", sent_cnt - base_s, 0);
        chk("t5_idle_tx", tx, 1'b1);
        rd = rx_q.size();
        add_exp(48'h0000000000FF);
        send(48'h0000000000FF, 1'b0, acc);
        wait_sent(e);
        chk("t5_latency", e - acc, FRAME_CYC);
        repeat (5) @(negedge clk);
        check_line("t5_bytes");

        // Back-to-back frames
        base_s = sent_cnt;
        a = {16'($urandom), $urandom};
        b = {16'($urandom), $urandom};
        add_exp(a);
        add_exp(b);
        send(a, 1'b0, acc);
        wait_sent(e);
        @(negedge clk);
        send(b, 1'b0, acc2);
        chk("t6_gap_ok", (acc2 - e) <= 2 + CPB, 1'b1);
        wait_sent(e2);
        chk("t6_latency", e2 - acc2, FRAME_CYC);
        repeat (5) @(negedge clk);
        check_line("t6_bytes");
        chk("t6_sent", sent_cnt - base_s, 2);

        // Random payloads and request styles
        for (int n = 0; n < 6; n++) begin
            a = {16'($urandom), $urandom};
            hold = 1'($urandom_range(0, 1));
            add_exp(a);
            send(a, hold, acc);
            wait_sent(e);
            chk("rnd_latency", e - acc, FRAME_CYC);
            repeat ($urandom_range(1, 4)) @(negedge clk);
            check_line("rnd_bytes");
        end

        chk("framing_errors", frm_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
